// File: rtl/div_pkg.sv
// Shared constants and FSM state type for the sequential 32-bit divider.
package div_pkg;

  localparam int XLEN = 32;
  localparam int DIV_ITER = 32;
  localparam logic [XLEN-1:0] INT_MIN = 32'h8000_0000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } div_state_e;

endpackage

// File: rtl/sub_32.sv
// 32-bit trial subtractor: diff = a - b, c_out = 1 when no borrow occurred.
module sub_32
  import div_pkg::*;
(
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic [XLEN-1:0] diff,
  output logic            c_out
);

  // a + ~b + 1; the carry out of the top bit is the inverted borrow
  assign {c_out, diff} = {1'b0, a} + {1'b0, ~b} + {{XLEN{1'b0}}, 1'b1};

endmodule

// File: rtl/div_seq_32bit.sv
// Iterative restoring divider for RV32 DIV/DIVU/REM/REMU.
// One quotient bit per cycle, MSB first, followed by a sign/corner-case fix-up.
// Optional build macro DIV_EARLY_OUT_EN: divide-by-zero, signed overflow and
// |dividend| < |divisor| skip the iteration phase and go straight to fix-up.
module div_seq_32bit
  import div_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            is_signed,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] quotient,
  output logic [XLEN-1:0] remainder,
  output logic            div_by_zero
);

  localparam logic [4:0] LAST_ITER = 5'(DIV_ITER - 1);

  div_state_e state;
  logic [4:0] cnt;

  // Operand copies kept for the corner-case checks in FIX
  logic [XLEN-1:0] dividend_q;
  logic [XLEN-1:0] divisor_q;
  logic            signed_q;
  logic            sign_q;
  logic            sign_r;

  // Iteration datapath: dq shifts dividend bits out and quotient bits in.
  // The partial remainder never exceeds the divisor magnitude after an
  // iteration, so only its low 32 bits are stored; r_shift carries bit 32.
  logic [XLEN-1:0] dq;
  logic [XLEN-1:0] dvs;
  logic [XLEN-1:0] r;
  logic [XLEN:0]   r_shift;
  logic [XLEN-1:0] diff;
  logic            no_borrow;
  logic            accept;

  logic [XLEN-1:0] abs_dividend;
  logic [XLEN-1:0] abs_divisor;
  logic            take;
  logic            early;

  function automatic logic [XLEN-1:0] neg(input logic [XLEN-1:0] x);
    return ~x + {{(XLEN-1){1'b0}}, 1'b1};
  endfunction

  // |x| only when operating signed and x is negative; |-2^31| wraps to 2^31
  function automatic logic [XLEN-1:0] mag(input logic [XLEN-1:0] x, input logic sgn);
    return (sgn && x[XLEN-1]) ? neg(x) : x;
  endfunction

  assign take         = start && ((state == IDLE) || (state == DONE));
  assign abs_dividend = mag(dividend, is_signed);
  assign abs_divisor  = mag(divisor, is_signed);

  assign r_shift = {r, dq[XLEN-1]};

  sub_32 u_sub (
    .a     (r_shift[XLEN-1:0]),
    .b     (dvs),
    .diff  (diff),
    .c_out (no_borrow)
  );

  // A set bit 32 means the shifted remainder already exceeds any 32-bit divisor
  assign accept = r_shift[XLEN] | no_borrow;

`ifdef DIV_EARLY_OUT_EN
  assign early = (divisor == '0) ||
                 (is_signed && (dividend == INT_MIN) && (divisor == '1)) ||
                 (abs_dividend < abs_divisor);
`else
  assign early = 1'b0;
`endif

  // Operand capture on an accepted start, then one restoring step per CALC cycle
  always_ff @(posedge clk) begin
    if (take) begin
      dividend_q <= dividend;
      divisor_q  <= divisor;
      signed_q   <= is_signed;
      dvs        <= abs_divisor;
      sign_q     <= is_signed & (dividend[XLEN-1] ^ divisor[XLEN-1]);
      sign_r     <= is_signed & dividend[XLEN-1];
      if (early) begin
        dq <= '0;
        r  <= abs_dividend;
      end else begin
        dq <= abs_dividend;
        r  <= '0;
      end
    end else if (state == CALC) begin
      r  <= accept ? diff : r_shift[XLEN-1:0];
      dq <= {dq[XLEN-2:0], accept};
    end
  end

  // Control FSM with registered status and result outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (take) begin
            busy  <= 1'b1;
            cnt   <= '0;
            state <= early ? FIX : CALC;
          end else begin
            state <= IDLE;
          end
        end
        CALC: begin
          cnt <= cnt + 5'd1;
          if (cnt == LAST_ITER) state <= FIX;
        end
        FIX: begin
          state <= DONE;
          busy  <= 1'b0;
          done  <= 1'b1;
          if (divisor_q == '0) begin
            quotient    <= '1;
            remainder   <= dividend_q;
            div_by_zero <= 1'b1;
          end else if (signed_q && (dividend_q == INT_MIN) && (divisor_q == '1)) begin
            quotient    <= INT_MIN;
            remainder   <= '0;
            div_by_zero <= 1'b0;
          end else begin
            quotient    <= sign_q ? neg(dq) : dq;
            remainder   <= sign_r ? neg(r) : r;
            div_by_zero <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_div_seq_32bit.sv
// Scoreboard testbench for div_seq_32bit: directed corner cases, sequencing
// scenarios and randomized operands checked against a plain-arithmetic model.
module tb_div_seq_32bit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        is_signed;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        busy;
  logic        done;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        div_by_zero;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  typedef struct {
    logic [31:0] q;
    logic [31:0] r;
    logic        dbz;
    int          due;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  div_seq_32bit dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .is_signed   (is_signed),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] mag(input logic [31:0] x, input logic s);
    return (s && x[31]) ? (32'd0 - x) : x;
  endfunction

  // Cycles from the start cycle to the done cycle
  function automatic int latency(input logic [31:0] a, input logic [31:0] b, input logic s);
`ifdef DIV_EARLY_OUT_EN
    if (b == 32'd0 || (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) || mag(a, s) < mag(b, s))
      return 2;
`endif
    return 34;
  endfunction

  // RISC-V division semantics from plain arithmetic
  task automatic model(input logic [31:0] a, input logic [31:0] b, input logic s,
                       output logic [31:0] q, output logic [31:0] r, output logic dbz);
    logic signed [31:0] sa;
    logic signed [31:0] sbv;
    sa  = a;
    sbv = b;
    dbz = 1'b0;
    if (b == 32'd0) begin
      q   = 32'hFFFF_FFFF;
      r   = a;
      dbz = 1'b1;
    end else if (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      q = 32'h8000_0000;
      r = 32'd0;
    end else if (s) begin
      q = sa / sbv;
      r = sa % sbv;
    end else begin
      q = a / b;
      r = a % b;
    end
  endtask

  // Drive one start pulse and record the expected response; returns at the
  // falling edge of the cycle after start
  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic s,
                       input logic [31:0] eq, input logic [31:0] er, input logic edbz);
    exp_t e;
    @(negedge clk);
    dividend  = a;
    divisor   = b;
    is_signed = s;
    start     = 1'b1;
    e.q   = eq;
    e.r   = er;
    e.dbz = edbz;
    e.due = cyc + latency(a, b, s);
    sb.push_back(e);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL %s_timeout: got %0d pending results expected 0", name, sb.size());
      sb.delete();
    end
  endtask

  // Monitor: every done pulse is matched against the oldest expectation
  always @(negedge clk) begin
    if (rst_n === 1'b1 && done === 1'b1) begin
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_done: got done at cycle %0d expected none", cyc);
      end else begin
        mon_e = sb.pop_front();
        check("quotient", quotient, mon_e.q);
        check("remainder", remainder, mon_e.r);
        check("div_by_zero", {31'd0, div_by_zero}, {31'd0, mon_e.dbz});
        check("done_cycle", cyc, mon_e.due);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a, b, q, r;
    logic        s, d;
    int          sel;

    rst_n     = 1'b0;
    start     = 1'b0;
    is_signed = 1'b0;
    dividend  = 32'd0;
    divisor   = 32'd0;
    repeat (3) @(negedge clk);
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_done", {31'd0, done}, 32'd0);
    check("reset_quotient", quotient, 32'd0);
    check("reset_remainder", remainder, 32'd0);
    check("reset_dbz", {31'd0, div_by_zero}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Unsigned 100 / 7 with busy window checks
    issue(32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 1'b0);
    check("busy_first_calc", {31'd0, busy}, 32'd1);
    repeat (32) @(negedge clk);
    check("busy_fix", {31'd0, busy}, 32'd1);
    check("done_before_fix_end", {31'd0, done}, 32'd0);
    @(negedge clk);
    check("busy_done_cycle", {31'd0, busy}, 32'd0);
    drain("u100_7");

    // Signed sign handling
    issue(32'hFFFF_FFF9, 32'd2, 1'b1, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0);
    drain("s_m7_2");
    issue(32'd7, 32'hFFFF_FFFE, 1'b1, 32'hFFFF_FFFD, 32'd1, 1'b0);
    drain("s_7_m2");

    // Divide by zero, both modes
    issue(32'h8000_0001, 32'd0, 1'b1, 32'hFFFF_FFFF, 32'h8000_0001, 1'b1);
    drain("s_div0");
    issue(32'h8000_0001, 32'd0, 1'b0, 32'hFFFF_FFFF, 32'h8000_0001, 1'b1);
    drain("u_div0");

    // Signed overflow
    issue(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 32'd0, 1'b0);
    drain("s_ovf");

    // Shifted remainder exceeding 32 bits
    issue(32'hFFFF_FFFF, 32'h8000_0001, 1'b0, 32'd1, 32'h7FFF_FFFE, 1'b0);
    drain("u_wide");

    // start during CALC must be ignored
    issue(32'd1000, 32'd3, 1'b0, 32'd333, 32'd1, 1'b0);
    repeat (5) @(negedge clk);
    dividend = 32'd5;
    divisor  = 32'd0;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    drain("ignored_start");
    repeat (40) @(negedge clk);

    // Back-to-back: start in the done cycle
    issue(32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 1'b0);
    repeat (32) @(negedge clk);
    issue(32'd1000, 32'd10, 1'b0, 32'd100, 32'd0, 1'b0);
    drain("back_to_back");

    // Reset in the middle of an operation drops it
    issue(32'd12345, 32'd7, 1'b0, 32'd1763, 32'd4, 1'b0);
    repeat (8) @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    sb.delete();
    @(negedge clk);
    check("midreset_busy", {31'd0, busy}, 32'd0);
    check("midreset_done", {31'd0, done}, 32'd0);
    check("midreset_quotient", quotient, 32'd0);
    check("midreset_remainder", remainder, 32'd0);
    check("midreset_dbz", {31'd0, div_by_zero}, 32'd0);
    rst_n = 1'b1;
    repeat (50) @(negedge clk);

    // Randomized operands against the model
    for (int i = 0; i < 150; i++) begin
      a   = $urandom;
      b   = $urandom;
      s   = 1'($urandom_range(0, 1));
      sel = $urandom_range(0, 7);
      case (sel)
        0: b = 32'd0;
        1: b = 32'hFFFF_FFFF;
        2: b = $urandom_range(1, 15);
        3: a = 32'h8000_0000;
        4: b = a >> $urandom_range(0, 31);
        5: a = $urandom_range(0, 100);
        default: ;
      endcase
      model(a, b, s, q, r, d);
      issue(a, b, s, q, r, d);
      drain("random");
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    repeat (5) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/div_seq_32bit.md
# div_seq_32bit

Iterative 32-bit restoring divider for the M-extension DIV/DIVU/REM/REMU path of the RV32 core. It takes one operand pair on a start pulse and produces quotient and remainder after a fixed multi-cycle latency, with RISC-V corner-case semantics. It is the consumer of the trial-subtract/compare primitive: each iteration it subtracts, reads the borrow, and decides the quotient bit.

## Interface
- XLEN, 32: operand width; only 32 is supported.
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  synchronous, active-low reset.
- start  in  1  request; accepted only in IDLE or DONE.
- is_signed  in  1  1 = DIV/REM semantics, 0 = DIVU/REMU; sampled with start.
- dividend  in  32  sampled with start.
- divisor  in  32  sampled with start.
- busy  out  1  high while an operation is in flight.
- done  out  1  one-cycle pulse; results valid in this cycle.
- quotient  out  32  registered; holds until the next done.
- remainder  out  32  registered; holds until the next done.
- div_by_zero  out  1  registered flag, qualified by done.

## Operation
- States: IDLE, CALC, FIX, DONE. Reset → IDLE.
- IDLE/DONE + start: latch |dividend| and |divisor|. Absolute value is taken only if is_signed is set and bit 31 is 1. Latch sign_q = sign(dividend) ^ sign(divisor) and sign_r = sign(dividend). Clear the 33-bit partial remainder and cnt = 0, then go to CALC.
- CALC, one bit per cycle, MSB first:
  - r_shift = {r[31:0], dq[31]}.
  - Trial subtract low 32 bits of r_shift minus divisor.
  - Accept if r_shift[32] | no-borrow. Accept: r = difference, q bit = 1. Reject: r = r_shift, q bit = 0.
  - cnt increments each cycle; after cnt = 31, go to FIX.
- FIX, applied in priority order, then go to DONE:
  - divisor == 0: quotient = 32'hFFFF_FFFF, remainder = original dividend, div_by_zero = 1.
  - Signed and dividend == 32'h8000_0000 and divisor == 32'hFFFF_FFFF: quotient = 32'h8000_0000, remainder = 0.
  - Otherwise: quotient = sign_q ? −q : q, remainder = sign_r ? −r : r, both truncated to 32 bits.
- DONE: done = 1 for this cycle. Next state is IDLE, or CALC if start is high.
- start in CALC/FIX is ignored and is not queued.
- Arithmetic is two's complement mod 2^32. |−2^31| is treated as the unsigned value 2^31.

## Timing
- Reset values: busy = 0, done = 0, quotient = 0, remainder = 0, div_by_zero = 0, state = IDLE.
- Example: start is high in cycle N.
  - CALC occupies cycles N+1..N+32.
  - FIX is cycle N+33.
  - done is high in cycle N+34.
  - busy is high in N+1..N+33 and low in the done cycle.
- Back-to-back: start in the done cycle N+34 produces the next done at N+68.
- rst_n low in any state: at the next edge, return to IDLE and zero all outputs. The in-flight operation is dropped and no done is produced.
- Outputs change only at the done edge or at reset.

## Configuration
- DIV_EARLY_OUT_EN defined: in IDLE/DONE with start, if divisor == 0, or the signed-overflow case applies, or |dividend| < |divisor| (unsigned magnitude), go directly to FIX.
  - done is then high at N+2.
  - For the |dividend| < |divisor| case, FIX uses q = 0 and r = |dividend|.
- Undefined: every operation takes the full 34-cycle path.
- Results are bit-identical in both builds; only latency differs.

## Structure
- Package div_pkg: XLEN constant, state enum type div_state_e (IDLE, CALC, FIX, DONE), and localparams DIV_ITER = 32 and INT_MIN = 32'h8000_0000.
- Sub-module: one instance of sub_32 for the trial subtract. Its c_out = 1 means no borrow.
- Sign fix-up, absolute value, and the FSM are inline. No other sub-modules.

## Test plan
- Unsigned 100 / 7 (is_signed = 0) → quotient = 14, remainder = 2, done at N+34, busy high N+1..N+33.
- Signed −7 / 2 → quotient = 32'hFFFF_FFFD (−3), remainder = 32'hFFFF_FFFF (−1). Signed 7 / −2 → quotient = −3, remainder = 1.
- Divisor 0 with dividend 32'h8000_0001, signed and unsigned → quotient = 32'hFFFF_FFFF, remainder = 32'h8000_0001, div_by_zero = 1. done at N+34, or at N+2 with DIV_EARLY_OUT_EN.
- Signed 32'h8000_0000 / 32'hFFFF_FFFF → quotient = 32'h8000_0000, remainder = 0, div_by_zero = 0.
- Unsigned 32'hFFFF_FFFF / 32'h8000_0001 → quotient = 1, remainder = 32'h7FFF_FFFE. This exercises the r_shift[32] accept path.
- Sequencing:
  - Assert start again during CALC → ignored.
  - Pull rst_n low at cycle N+10 → no done is produced and outputs are 0.
  - Start at the done cycle → second result at N+68.
